// File: rtl/layer00_pkg.sv
// Shared layer-00 constants, FSM state type and bank slicing used by the save and load blocks.
package layer00_pkg;

  localparam int unsigned NUM_BANK       = 16;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned BANK_W         = 8;
  localparam int unsigned LINE_W         = NUM_BANK * BANK_W;
  localparam int unsigned BEAT_W         = 32;
  localparam int unsigned BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int unsigned RD_LAT         = 1;
  localparam int unsigned LBUF_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/layer00_line_fifo.sv
// Two-entry line buffer between the bank read port and the beat unpacker.
// Exposes the head line and the line behind it so the unpacker can preload its output register.
module layer00_line_fifo
  import layer00_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [LINE_W-1:0] head,
  output logic [LINE_W-1:0] next_line,
  output logic [1:0]        count
);

  logic [LINE_W-1:0] mem [LBUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LBUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head      = mem[rd_ptr];
    next_line = mem[~rd_ptr];
  end

endmodule

// File: rtl/layer00_load.sv
// Layer-00 load path: reads 128-bit lines from the byte-lane banks and streams them as 32-bit beats.
// Optional stall counter output o_stall_cnt when LAYER00_LOAD_STALL_CNT_EN is defined.
module layer00_load
  import layer00_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [ADDR_W-1:0]          i_num_lines,
  output logic                       o_rd_en,
  output logic [NUM_BANK*ADDR_W-1:0] o_addr,
  input  logic [NUM_BANK*BANK_W-1:0] i_rdata,
  output logic [BEAT_W-1:0]          o_ofm,
  output logic                       o_vld,
  input  logic                       i_rdy,
  output logic                       o_busy,
  output logic                       o_done
`ifdef LAYER00_LOAD_STALL_CNT_EN
  ,
  output logic [15:0]                o_stall_cnt
`endif
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, num_q, issued_q, line_addr;
  logic [ADDR_W:0]     issued_inc;
  logic [RD_LAT-1:0]   rd_pipe;
  logic [1:0]          beat_q, beat_d;
  logic [BEAT_W-1:0]   ofm_q, ofm_d;
  logic                done_q;
  logic [LINE_W-1:0]   head, next_line, head_d;
  logic [1:0]          fifo_cnt;
  logic [2:0]          occ;
  logic                start_ok, last_issue, hs, pop, cap, final_hs;

  layer00_line_fifo u_line_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (cap),
    .wr_data   (i_rdata),
    .rd_en     (pop),
    .head      (head),
    .next_line (next_line),
    .count     (fifo_cnt)
  );

  always_comb begin
    start_ok   = i_start && (state_q == ST_IDLE);
    occ        = 3'(fifo_cnt) + 3'($countones(rd_pipe));
    o_rd_en    = (state_q == ST_RUN) && (occ < 3'(LBUF_DEPTH));
    line_addr  = base_q + issued_q;
    issued_inc = {1'b0, issued_q} + (ADDR_W+1)'(1);
    last_issue = o_rd_en && (issued_inc == {1'b0, num_q});
    o_vld      = (fifo_cnt != 2'd0);
    hs         = o_vld && i_rdy;
    pop        = hs && (beat_q == 2'(BEATS_PER_LINE - 1));
    cap        = rd_pipe[RD_LAT-1];
    final_hs   = (state_q == ST_FLUSH) && pop && (fifo_cnt == 2'd1) && (rd_pipe == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok && (i_num_lines != '0)) state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_FLUSH;
      ST_FLUSH: if (final_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // o_ofm is registered, so select next cycle's head line: a same-cycle capture
  // or the second entry may become the head as the current one pops.
  always_comb begin
    beat_d = hs ? beat_q + 2'd1 : beat_q;
    head_d = head;
    unique case (fifo_cnt)
      2'd0:    if (cap) head_d = i_rdata;
      2'd1:    if (pop && cap) head_d = i_rdata;
      2'd2:    if (pop) head_d = next_line;
      default: head_d = head;
    endcase
    ofm_d = head_d[int'(beat_d)*BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      rd_pipe  <= '0;
      beat_q   <= '0;
      ofm_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_pipe <= RD_LAT'({rd_pipe, o_rd_en});
      if (start_ok) begin
        base_q   <= i_base_addr;
        num_q    <= i_num_lines;
        issued_q <= '0;
      end else if (o_rd_en) begin
        issued_q <= issued_q + ADDR_W'(1);
      end
      beat_q <= beat_d;
      ofm_q  <= ofm_d;
      done_q <= (start_ok && (i_num_lines == '0)) || final_hs;
    end
  end

  always_comb begin
    o_addr = {NUM_BANK{line_addr}};
    o_ofm  = ofm_q;
    o_busy = (state_q != ST_IDLE);
    o_done = done_q;
  end

`ifdef LAYER00_LOAD_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (o_vld && !i_rdy && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  always_comb o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_layer00_load.sv
// Directed scoreboard bench for layer00_load: expected beats queued at start, popped on each handshake.
module tb_layer00_load;
  import layer00_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_start;
  logic [ADDR_W-1:0]          i_base_addr;
  logic [ADDR_W-1:0]          i_num_lines;
  logic                       o_rd_en;
  logic [NUM_BANK*ADDR_W-1:0] o_addr;
  logic [LINE_W-1:0]          i_rdata;
  logic [BEAT_W-1:0]          o_ofm;
  logic                       o_vld;
  logic                       i_rdy;
  logic                       o_busy;
  logic                       o_done;
`ifdef LAYER00_LOAD_STALL_CNT_EN
  logic [15:0]                o_stall_cnt;
`endif

  layer00_load dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_num_lines (i_num_lines),
    .o_rd_en     (o_rd_en),
    .o_addr      (o_addr),
    .i_rdata     (i_rdata),
    .o_ofm       (o_ofm),
    .o_vld       (o_vld),
    .i_rdy       (i_rdy),
    .o_busy      (o_busy),
    .o_done      (o_done)
`ifdef LAYER00_LOAD_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [LINE_W-1:0] mem [1024];
  always @(posedge clk) if (o_rd_en) i_rdata <= mem[o_addr[ADDR_W-1:0]];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BEAT_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] rd_log [$];
  int checks = 0;
  int errors = 0;
  int unsigned done_cnt = 0, done_cyc = 0, beats = 0, issued_lines = 0;
  int unsigned first_vld_cyc = 0, last_hs_cyc = 0, vld_cyc_cnt = 0, stall_cycles = 0;
  int unsigned start_cyc = 0;
  bit vld_seen = 0, prev_stall = 0;
  logic [BEAT_W-1:0] prev_ofm;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert ({o_vld, o_ofm} === {1'b1, prev_ofm})
          else begin errors++; $error("FAIL stall_hold got=%b/%h exp=1/%h", o_vld, o_ofm, prev_ofm); end
      end
      if (o_rd_en) begin
        logic [ADDR_W-1:0] a;
        a = o_addr[ADDR_W-1:0];
        checks++;
        assert (o_addr === {NUM_BANK{a}})
          else begin errors++; $error("FAIL bank_addr got=%h exp=%h", o_addr, {NUM_BANK{a}}); end
        rd_log.push_back(a);
        issued_lines++;
        checks++;
        assert (issued_lines - beats / 4 <= 2)
          else begin errors++; $error("FAIL credit got=%0d exp<=2", issued_lines - beats / 4); end
      end
      if (o_vld) begin
        vld_cyc_cnt++;
        if (!vld_seen) first_vld_cyc = cyc;
        vld_seen = 1;
      end
      if (o_vld && i_rdy) begin
        beats++;
        last_hs_cyc = cyc;
        checks++;
        assert (exp_q.size() != 0)
          else begin errors++; $error("FAIL extra_beat got=%h exp=none", o_ofm); end
        if (exp_q.size() != 0) begin
          logic [BEAT_W-1:0] e;
          e = exp_q.pop_front();
          checks++;
          assert (o_ofm === e)
            else begin errors++; $error("FAIL beat got=%h exp=%h", o_ofm, e); end
        end
      end
      prev_stall = o_vld && !i_rdy;
      if (prev_stall) stall_cycles++;
      prev_ofm = o_ofm;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp)
      else begin errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] n,
                            input bit fresh);
    @(posedge clk); #2;
    i_base_addr = base;
    i_num_lines = n;
    i_start     = 1'b1;
    if (fresh) begin
      for (int unsigned l = 0; l < n; l++) begin
        logic [ADDR_W-1:0] a;
        a = base + ADDR_W'(l);
        for (int unsigned k = 0; k < BEATS_PER_LINE; k++) exp_q.push_back(mem[a][32*k +: 32]);
      end
      rd_log.delete();
      beats = 0; issued_lines = 0; vld_seen = 0; vld_cyc_cnt = 0; stall_cycles = 0;
    end
    @(posedge clk); #2;
    start_cyc = cyc;
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned bound, input bit bp);
    int unsigned d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int unsigned i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (bp) i_rdy = (i % 4 == 3);
      if (done_cnt != d0) begin ok = 1; break; end
    end
    i_rdy = 1'b1;
    checks++;
    assert (ok) else begin errors++; $error("FAIL done_timeout got=0 exp=1"); end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_addr"},  longint'(o_addr != '0), 0);
    chk({tag, "_ofm"},   o_ofm, 0);
    chk({tag, "_vld"},   o_vld, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
  endtask

  initial begin
    int unsigned d0;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 4; k++) mem[i][32*k +: 32] = {16'(i), 8'hA5, 8'(k)};
    mem[0] = 128'h44444444_33333333_22222222_11111111;
    rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_lines = '0; i_rdy = 1'b1;
    i_rdata = '0;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;

    // single line, literal beats
    start_xfer(10'd0, 10'd1, 1);
    wait_done(50, 0);
    idle(2);
    chk("t1_latency", first_vld_cyc - start_cyc, 2);
    chk("t1_done_after_last", done_cyc - last_hs_cyc, 1);
    chk("t1_beats", beats, 4);
    chk("t1_vld_cycles", vld_cyc_cnt, 4);
    chk("t1_rd_count", rd_log.size(), 1);
    if (rd_log.size() == 1) chk("t1_rd_addr", rd_log[0], 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // four lines, no bubbles
    start_xfer(10'd0, 10'd4, 1);
    wait_done(100, 0);
    idle(2);
    chk("t2_beats", beats, 16);
    chk("t2_vld_cycles", vld_cyc_cnt, 16);
    chk("t2_span", last_hs_cyc - first_vld_cyc, 15);
    chk("t2_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t2_rd_addr", rd_log[i], i);

    // backpressure
    start_xfer(10'd40, 10'd5, 1);
    wait_done(400, 1);
    idle(2);
    chk("t3_beats", beats, 20);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_stalled", longint'(stall_cycles > 20), 1);
`ifdef LAYER00_LOAD_STALL_CNT_EN
    chk("t3_stall_cnt", o_stall_cnt, stall_cycles);
`endif

    // address wrap
    start_xfer(10'd1022, 10'd3, 1);
    wait_done(100, 0);
    idle(2);
    chk("t4_beats", beats, 12);
    chk("t4_rd_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("t4_rd0", rd_log[0], 1022);
      chk("t4_rd1", rd_log[1], 1023);
      chk("t4_rd2", rd_log[2], 0);
    end

    // zero-length start
    d0 = done_cnt;
    start_xfer(10'd5, 10'd0, 1);
    chk("t5_done", o_done, 1);
    chk("t5_busy", o_busy, 0);
    idle(3);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_done_cyc", done_cyc, start_cyc);
    chk("t5_no_reads", rd_log.size(), 0);

    // start while busy is ignored
    start_xfer(10'd60, 10'd2, 1);
    idle(3);
    start_xfer(10'd100, 10'd5, 0);
    d0 = done_cnt;
    wait_done(100, 0);
    idle(3);
    chk("t6_beats", beats, 8);
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_rd_count", rd_log.size(), 2);
    if (rd_log.size() == 2) chk("t6_rd1", rd_log[1], 61);
    chk("t6_sb_empty", exp_q.size(), 0);

    // reset with a read in flight
    start_xfer(10'd20, 10'd4, 1);
    d0 = done_cnt;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("t7_no_done", done_cnt - d0, 0);
    start_xfer(10'd8, 10'd1, 1);
    wait_done(50, 0);
    idle(3);
    chk("t7_beats", beats, 4);
    chk("t7_sb_empty", exp_q.size(), 0);
    chk("t7_rd_count", rd_log.size(), 1);
    if (rd_log.size() == 1) chk("t7_rd_addr", rd_log[0], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
